vga_rx: RTL

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_rx_if.sv | 28 ++
 rtl/vga_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_if.sv
// rtl/vga_rx_if.sv - incoming VGA video and captured-pixel signal bundle for vga_rx
// master drives the video side, slave is the receiver that produces pix_*.
interface vga_rx_if #(
  parameter int C_SIZE = 10
);
  logic              h_sync;
  logic              v_sync;
  logic [2:0]        red;
  logic [2:0]        green;
  logic [1:0]        blue;

  logic              pix_valid;
  logic [C_SIZE-1:0] pix_x;
  logic [C_SIZE-1:0] pix_y;
  logic [2:0]        pix_red;
  logic [2:0]        pix_green;
  logic [1:0]        pix_blue;

  modport master (
    output h_sync, v_sync, red, green, blue,
    input  pix_valid, pix_x, pix_y, pix_red, pix_green, pix_blue
  );

  modport slave (
    input  h_sync, v_sync, red, green, blue,
    output pix_valid, pix_x, pix_y, pix_red, pix_green, pix_blue
  );
endinterface

// File: rtl/vga_rx.sv
// rtl/vga_rx.sv - VGA timing receiver: sync lock tracking, pixel coordinates and colour capture
// Define VGA_RX_MEASURE_EN to add the h_total/v_total measurement outputs.
module vga_rx #(
  parameter int THADDR = 640,
  parameter int THFP   = 16,
  parameter int THS    = 96,
  parameter int THBP   = 48,
  parameter int TVADDR = 480,
  parameter int TVFP   = 10,
  parameter int TVS    = 2,
  parameter int TVBP   = 33,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0,
  parameter int C_SIZE = 10
) (
  input  logic    pixel_clock,
  input  logic    reset,
  vga_rx_if.slave vid,
  output logic    locked,
  output logic    frame_start,
  output logic    timing_err
`ifdef VGA_RX_MEASURE_EN
  ,
  output logic [C_SIZE-1:0] h_total,
  output logic [C_SIZE-1:0] v_total
`endif
);

  localparam int HT      = THADDR + THFP + THS + THBP;
  localparam int VT      = TVADDR + TVFP + TVS + TVBP;
  localparam int H_START = THS + THBP;
  localparam int H_END   = H_START + THADDR;
  localparam int V_START = TVS + TVBP;
  localparam int V_END   = V_START + TVADDR;

  localparam logic [C_SIZE:0]   HT_W    = HT[C_SIZE:0];
  localparam logic [C_SIZE:0]   VT_W    = VT[C_SIZE:0];
  localparam logic [C_SIZE-1:0] H_ST_W  = H_START[C_SIZE-1:0];
  localparam logic [C_SIZE-1:0] H_END_W = H_END[C_SIZE-1:0];
  localparam logic [C_SIZE-1:0] V_ST_W  = V_START[C_SIZE-1:0];
  localparam logic [C_SIZE-1:0] V_END_W = V_END[C_SIZE-1:0];
  localparam logic [C_SIZE-1:0] CNT_MAX = '1;

  localparam logic HS_ACT = (H_POL != 0);
  localparam logic VS_ACT = (V_POL != 0);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Input stage S1 plus the previous S1 sync sample for edge detection
  logic        r_hs1;
  logic        r_vs1;
  logic        r_hs1_q;
  logic        r_vs1_q;
  logic [2:0]  r_red1;
  logic [2:0]  r_green1;
  logic [1:0]  r_blue1;

  logic [C_SIZE-1:0] r_h_cnt;
  logic [C_SIZE-1:0] r_v_cnt;
  logic              r_vs_pend;

  state_t      r_state;
  logic        r_trk_err;
  logic        r_locked;
  logic        r_frame_start;
  logic        r_timing_err;

  logic              r_pix_valid;
  logic [C_SIZE-1:0] r_pix_x;
  logic [C_SIZE-1:0] r_pix_y;
  logic [2:0]        r_pix_red;
  logic [2:0]        r_pix_green;
  logic [1:0]        r_pix_blue;

  logic              w_hs_start;
  logic              w_vs_start;
  logic [C_SIZE:0]   w_h_inc;
  logic [C_SIZE-1:0] w_h_sat;
  logic [C_SIZE-1:0] w_h_cur;
  logic [C_SIZE:0]   w_v_inc;
  logic [C_SIZE-1:0] w_v_sat;
  logic [C_SIZE-1:0] w_v_cur;
  logic              w_new_frame;
  logic              w_line_err;
  logic              w_frame_err;
  logic              w_mismatch;
  logic              w_lock_next;
  logic              w_active;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_hs1    <= ~HS_ACT;
      r_vs1    <= ~VS_ACT;
      r_hs1_q  <= ~HS_ACT;
      r_vs1_q  <= ~VS_ACT;
      r_red1   <= 3'd0;
      r_green1 <= 3'd0;
      r_blue1  <= 2'd0;
    end else begin
      r_hs1    <= vid.h_sync;
      r_vs1    <= vid.v_sync;
      r_hs1_q  <= r_hs1;
      r_vs1_q  <= r_vs1;
      r_red1   <= vid.red;
      r_green1 <= vid.green;
      r_blue1  <= vid.blue;
    end
  end

  assign w_hs_start = (r_hs1 == HS_ACT) && (r_hs1_q != HS_ACT);
  assign w_vs_start = (r_vs1 == VS_ACT) && (r_vs1_q != VS_ACT);

  // w_h_cur / w_v_cur are the coordinates of the sample currently in S1
  assign w_h_inc = {1'b0, r_h_cnt} + 1'b1;
  assign w_h_sat = (r_h_cnt == CNT_MAX) ? CNT_MAX : w_h_inc[C_SIZE-1:0];
  assign w_h_cur = w_hs_start ? '0 : w_h_sat;

  assign w_v_inc     = {1'b0, r_v_cnt} + 1'b1;
  assign w_v_sat     = (r_v_cnt == CNT_MAX) ? CNT_MAX : w_v_inc[C_SIZE-1:0];
  assign w_new_frame = w_vs_start || r_vs_pend;
  assign w_v_cur     = w_hs_start ? (w_new_frame ? '0 : w_v_sat) : r_v_cnt;

  // A coincident hsync is counted into the ending frame, hence r_v_cnt + 1
  assign w_line_err  = w_hs_start ? (w_h_inc != HT_W) : ({1'b0, w_h_cur} == HT_W);
  assign w_frame_err = (w_v_inc != VT_W);
  assign w_mismatch  = w_line_err || (w_vs_start && w_frame_err);

  assign w_lock_next = ((r_state == LOCKED) && !w_mismatch) ||
                       ((r_state == TRACK) && w_vs_start && !w_mismatch && !r_trk_err);

  assign w_active = (w_h_cur >= H_ST_W) && (w_h_cur < H_END_W) &&
                    (w_v_cur >= V_ST_W) && (w_v_cur < V_END_W);

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_vs_pend <= 1'b0;
    end else begin
      r_h_cnt <= w_h_cur;
      r_v_cnt <= w_v_cur;
      if (w_hs_start) begin
        r_vs_pend <= 1'b0;
      end else if (w_vs_start) begin
        r_vs_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_state       <= SEARCH;
      r_trk_err     <= 1'b0;
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
      r_timing_err  <= 1'b0;
    end else begin
      r_locked      <= w_lock_next;
      r_frame_start <= w_vs_start && w_lock_next;
      r_timing_err  <= w_mismatch && (r_state != SEARCH);
      case (r_state)
        SEARCH: begin
          if (w_vs_start) begin
            r_state   <= TRACK;
            r_trk_err <= 1'b0;
          end
        end
        TRACK: begin
          if (w_vs_start) begin
            if (w_lock_next) begin
              r_state <= LOCKED;
            end
            r_trk_err <= 1'b0;
          end else if (w_mismatch) begin
            r_trk_err <= 1'b1;
          end
        end
        LOCKED: begin
          if (w_mismatch) begin
            r_state <= SEARCH;
          end
        end
        default: begin
          r_state <= SEARCH;
        end
      endcase
    end
  end

  // pix_* are zero outside valid pixels so stale colour never leaks
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_red   <= 3'd0;
      r_pix_green <= 3'd0;
      r_pix_blue  <= 2'd0;
    end else if (w_active && w_lock_next) begin
      r_pix_valid <= 1'b1;
      r_pix_x     <= w_h_cur - H_ST_W;
      r_pix_y     <= w_v_cur - V_ST_W;
      r_pix_red   <= r_red1;
      r_pix_green <= r_green1;
      r_pix_blue  <= r_blue1;
    end else begin
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_red   <= 3'd0;
      r_pix_green <= 3'd0;
      r_pix_blue  <= 2'd0;
    end
  end

`ifdef VGA_RX_MEASURE_EN
  logic [C_SIZE-1:0] r_h_total;
  logic [C_SIZE-1:0] r_v_total;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_h_total <= '0;
      r_v_total <= '0;
    end else begin
      if (w_hs_start) begin
        r_h_total <= w_h_sat;
      end
      if (w_vs_start) begin
        r_v_total <= w_v_sat;
      end
    end
  end

  assign h_total = r_h_total;
  assign v_total = r_v_total;
`endif

  assign vid.pix_valid = r_pix_valid;
  assign vid.pix_x     = r_pix_x;
  assign vid.pix_y     = r_pix_y;
  assign vid.pix_red   = r_pix_red;
  assign vid.pix_green = r_pix_green;
  assign vid.pix_blue  = r_pix_blue;

  assign locked      = r_locked;
  assign frame_start = r_frame_start;
  assign timing_err  = r_timing_err;

endmodule
